// File: rtl/fpr_wb_ctl_if.sv
// Write-back bus bundle for the FPR write-back controller: issue allocation,
// FPU result handshake, load data, register-file write port and status.
interface fpr_wb_ctl_if #(
  parameter int FPLEN = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             alloc_valid;
  logic [4:0]       alloc_addr;
  logic             fpu_valid;
  logic             fpu_ready;
  logic [4:0]       fpu_addr;
  logic [FPLEN-1:0] fpu_data;
  logic             ld_valid;
  logic [4:0]       ld_addr;
  logic [FPLEN-1:0] ld_data;
  logic             wen0;
  logic [4:0]       waddr0;
  logic [FPLEN-1:0] wd0;
  logic [31:0]      busy;
  logic [CW-1:0]    fifo_count;
  logic             wr_err;

  modport master (
    output flush, alloc_valid, alloc_addr,
    output fpu_valid, fpu_addr, fpu_data,
    output ld_valid, ld_addr, ld_data,
    input  fpu_ready, wen0, waddr0, wd0, busy, fifo_count, wr_err
  );

  modport slave (
    input  flush, alloc_valid, alloc_addr,
    input  fpu_valid, fpu_addr, fpu_data,
    input  ld_valid, ld_addr, ld_data,
    output fpu_ready, wen0, waddr0, wd0, busy, fifo_count, wr_err
  );
endinterface

// File: rtl/fpr_wb_ctl.sv
// FPR write-back controller: single writer of the FPR write port, merging
// priority load data with FIFO-buffered FPU results, plus a pending-write scoreboard.
module fpr_wb_ctl #(
  parameter int FPLEN = 32,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_l,
  fpr_wb_ctl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [FPLEN-1:0] mem_data_r [DEPTH];
  logic [4:0]       mem_addr_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [31:0]      busy_r;
  logic             err_r;
  logic             wen0_r;
  logic [4:0]       waddr0_r;
  logic [FPLEN-1:0] wd0_r;

  logic             full_s;
  logic             empty_s;
  logic             fpu_ready_s;
  logic             hs_s;
  logic             wr_en_s;
  logic [4:0]       wr_addr_s;
  logic [FPLEN-1:0] wr_data_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      busy_nxt_s;
  logic             err_nxt_s;
  logic [CW-1:0]    count_nxt_s;

  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == {CW{1'b0}});
  // A full FIFO rejects even when popping this cycle; the producer retries.
  assign fpu_ready_s = rst_l & ~bus.flush & ~full_s;
  assign hs_s        = bus.fpu_valid & fpu_ready_s;

  // Write-source selection: load first, then FIFO head, then FPU bypass.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 5'd0;
    wr_data_s = {FPLEN{1'b0}};
    push_s    = 1'b0;
    pop_s     = 1'b0;
    if (bus.ld_valid) begin
      wr_en_s   = 1'b1;
      wr_addr_s = bus.ld_addr;
      wr_data_s = bus.ld_data;
      push_s    = hs_s;
    end else if (!empty_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = mem_addr_r[rd_ptr_r];
      wr_data_s = mem_data_r[rd_ptr_r];
      pop_s     = 1'b1;
      push_s    = hs_s;
    end else if (hs_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = bus.fpu_addr;
      wr_data_s = bus.fpu_data;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Scoreboard, error flag and occupancy next-state.
  always_comb begin
    busy_nxt_s  = busy_r;
    err_nxt_s   = err_r;
    count_nxt_s = count_r;
    if (bus.flush) begin
      busy_nxt_s  = 32'd0;
      err_nxt_s   = 1'b0;
      count_nxt_s = {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        // Error is judged on the scoreboard as it stood before this edge.
        if (!busy_r[wr_addr_s]) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
        busy_nxt_s[wr_addr_s] = 1'b0;
      end else begin
        err_nxt_s = err_r;
      end
      // Allocation is applied after the clear so a same-address set wins.
      if (bus.alloc_valid) begin
        busy_nxt_s[bus.alloc_addr] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      busy_r   <= 32'd0;
      err_r    <= 1'b0;
      wen0_r   <= 1'b0;
      waddr0_r <= 5'd0;
      wd0_r    <= {FPLEN{1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      err_r   <= err_nxt_s;
      count_r <= count_nxt_s;
      if (bus.flush) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      wen0_r <= wr_en_s & ~bus.flush;
      if (wr_en_s && !bus.flush) begin
        waddr0_r <= wr_addr_s;
        wd0_r    <= wr_data_s;
      end
    end
  end

  // FIFO storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= bus.fpu_addr;
      mem_data_r[wr_ptr_r] <= bus.fpu_data;
    end
  end

  assign bus.fpu_ready  = fpu_ready_s;
  assign bus.wen0       = wen0_r;
  assign bus.waddr0     = waddr0_r;
  assign bus.wd0        = wd0_r;
  assign bus.busy       = busy_r;
  assign bus.fifo_count = count_r;
  assign bus.wr_err     = err_r;
endmodule

// File: tb/tb_fpr_wb_ctl.sv
// Testbench for fpr_wb_ctl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fpr_wb_ctl;
  localparam int FPLEN = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fpr_wb_ctl_if #(.FPLEN(FPLEN), .DEPTH(DEPTH)) bus ();
  fpr_wb_ctl #(.FPLEN(FPLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst_l(rst_l), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    bus.flush = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_addr = 5'd0;
    bus.fpu_valid = 1'b0; bus.fpu_addr = 5'd0; bus.fpu_data = 32'd0;
    bus.ld_valid = 1'b0; bus.ld_addr = 5'd0; bus.ld_data = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_l = 1'b0;
    #2;
    checks++; if (bus.wen0 !== 1'b0) begin failures++; $display("FAIL reset_wen0: got %0h want 0", bus.wen0); end
    checks++; if (bus.waddr0 !== 5'd0) begin failures++; $display("FAIL reset_waddr0: got %0h want 0", bus.waddr0); end
    checks++; if (bus.wd0 !== 32'd0) begin failures++; $display("FAIL reset_wd0: got %0h want 0", bus.wd0); end
    checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.wr_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0h want 0", bus.wr_err); end
    checks++; if (bus.fpu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0h want 0", bus.fpu_ready); end
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    checks++; if (bus.wen0 !== 1'b0) begin failures++; $display("FAIL reset_release_wen0: got %0h want 0", bus.wen0); end
  endtask

  task automatic test_load();
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd3; bus.ld_data = 32'h3F800000;
    tick();
    checks++; if (bus.wen0 !== 1'b1) begin failures++; $display("FAIL load_wen0: got %0h want 1", bus.wen0); end
    checks++; if (bus.waddr0 !== 5'd3) begin failures++; $display("FAIL load_waddr0: got %0d want 3", bus.waddr0); end
    checks++; if (bus.wd0 !== 32'h3F800000) begin failures++; $display("FAIL load_wd0: got %0h want 3f800000", bus.wd0); end
    checks++; if (bus.wr_err !== 1'b1) begin failures++; $display("FAIL load_err: got %0h want 1", bus.wr_err); end
    idle();
    tick();
    checks++; if (bus.wen0 !== 1'b0) begin failures++; $display("FAIL load_idle_wen0: got %0h want 0", bus.wen0); end
    checks++; if (bus.wr_err !== 1'b1) begin failures++; $display("FAIL load_err_sticky: got %0h want 1", bus.wr_err); end
    bus.flush = 1'b1;
    tick();
    idle();
    checks++; if (bus.wr_err !== 1'b0) begin failures++; $display("FAIL load_err_flush: got %0h want 0", bus.wr_err); end
  endtask

  task automatic test_bypass();
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd5;
    tick();
    idle();
    checks++; if (bus.busy[5] !== 1'b1) begin failures++; $display("FAIL bypass_alloc: got %0h want 1", bus.busy[5]); end
    bus.fpu_valid = 1'b1; bus.fpu_addr = 5'd5; bus.fpu_data = 32'h40490FDB;
    #1;
    checks++; if (bus.fpu_ready !== 1'b1) begin failures++; $display("FAIL bypass_ready: got %0h want 1", bus.fpu_ready); end
    tick();
    idle();
    checks++; if (bus.wen0 !== 1'b1) begin failures++; $display("FAIL bypass_wen0: got %0h want 1", bus.wen0); end
    checks++; if (bus.waddr0 !== 5'd5) begin failures++; $display("FAIL bypass_waddr0: got %0d want 5", bus.waddr0); end
    checks++; if (bus.wd0 !== 32'h40490FDB) begin failures++; $display("FAIL bypass_wd0: got %0h want 40490fdb", bus.wd0); end
    checks++; if (bus.busy[5] !== 1'b0) begin failures++; $display("FAIL bypass_busy: got %0h want 0", bus.busy[5]); end
    checks++; if (bus.wr_err !== 1'b0) begin failures++; $display("FAIL bypass_err: got %0h want 0", bus.wr_err); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL bypass_count: got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_backpressure();
    logic [4:0]  fa [5];
    logic [31:0] fd [5];
    int nxt = 0;
    for (int i = 0; i < 5; i++) begin
      fa[i] = 5'(20 + i);
      fd[i] = $urandom;
    end
    for (int c = 0; c < 6; c++) begin
      bus.ld_valid = 1'b1; bus.ld_addr = 5'(10 + c); bus.ld_data = $urandom;
      bus.fpu_valid = 1'b1; bus.fpu_addr = fa[nxt]; bus.fpu_data = fd[nxt];
      #1;
      checks++; if (bus.fpu_ready !== (c < 4)) begin failures++; $display("FAIL bp_ready[%0d]: got %0h want %0h", c, bus.fpu_ready, (c < 4)); end
      tick();
      if (c < 4) nxt++;
      checks++; if (bus.waddr0 !== 5'(10 + c) || bus.wen0 !== 1'b1) begin failures++; $display("FAIL bp_load[%0d]: got wen=%0h addr=%0d want wen=1 addr=%0d", c, bus.wen0, bus.waddr0, 10 + c); end
      checks++; if (bus.fifo_count !== CW'((c < 4) ? c + 1 : 4)) begin failures++; $display("FAIL bp_count[%0d]: got %0d want %0d", c, bus.fifo_count, (c < 4) ? c + 1 : 4); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== fa[k] || bus.wd0 !== fd[k]) begin failures++; $display("FAIL bp_drain[%0d]: got wen=%0h addr=%0d data=%0h want wen=1 addr=%0d data=%0h", k, bus.wen0, bus.waddr0, bus.wd0, fa[k], fd[k]); end
      checks++; if (bus.fifo_count !== CW'(3 - k)) begin failures++; $display("FAIL bp_drain_count[%0d]: got %0d want %0d", k, bus.fifo_count, 3 - k); end
    end
    bus.fpu_valid = 1'b1; bus.fpu_addr = fa[4]; bus.fpu_data = fd[4];
    tick();
    idle();
    checks++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== fa[4] || bus.wd0 !== fd[4]) begin failures++; $display("FAIL bp_e_bypass: got wen=%0h addr=%0d data=%0h want wen=1 addr=%0d data=%0h", bus.wen0, bus.waddr0, bus.wd0, fa[4], fd[4]); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL bp_e_count: got %0d want 0", bus.fifo_count); end
    bus.flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_alloc_collision();
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = 32'h12345678;
    bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd7;
    tick();
    idle();
    checks++; if (bus.busy[7] !== 1'b1) begin failures++; $display("FAIL collide_set_wins: got %0h want 1", bus.busy[7]); end
    checks++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd7) begin failures++; $display("FAIL collide_write: got wen=%0h addr=%0d want wen=1 addr=7", bus.wen0, bus.waddr0); end
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = 32'h9ABCDEF0;
    tick();
    idle();
    checks++; if (bus.busy[7] !== 1'b0) begin failures++; $display("FAIL collide_clear: got %0h want 0", bus.busy[7]); end
    bus.flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 4; c++) begin
      bus.alloc_valid = 1'b1; bus.alloc_addr = 5'(4 + c);
      bus.ld_valid = 1'b1; bus.ld_addr = 5'd1; bus.ld_data = $urandom;
      bus.fpu_valid = (c < 3); bus.fpu_addr = 5'd9; bus.fpu_data = $urandom;
      tick();
    end
    idle();
    checks++; if (bus.fifo_count !== 3'd3) begin failures++; $display("FAIL flush_pre_count: got %0d want 3", bus.fifo_count); end
    checks++; if (bus.busy !== 32'h000000F0) begin failures++; $display("FAIL flush_pre_busy: got %0h want f0", bus.busy); end
    bus.flush = 1'b1; bus.ld_valid = 1'b1; bus.ld_addr = 5'd2; bus.ld_data = 32'hDEADBEEF;
    bus.fpu_valid = 1'b1; bus.fpu_addr = 5'd11; bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd12;
    #1;
    checks++; if (bus.fpu_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_during: got %0h want 0", bus.fpu_ready); end
    tick();
    idle();
    #1;
    checks++; if (bus.wen0 !== 1'b0) begin failures++; $display("FAIL flush_wen0: got %0h want 0", bus.wen0); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL flush_busy: got %0h want 0", bus.busy); end
    checks++; if (bus.wr_err !== 1'b0) begin failures++; $display("FAIL flush_err: got %0h want 0", bus.wr_err); end
    checks++; if (bus.fpu_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after: got %0h want 1", bus.fpu_ready); end
    tick();
    checks++; if (bus.wen0 !== 1'b0) begin failures++; $display("FAIL flush_no_stale_write: got %0h want 0", bus.wen0); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      bus.ld_valid = 1'b1; bus.ld_addr = 5'd1; bus.ld_data = $urandom;
      bus.fpu_valid = 1'b1; bus.fpu_addr = 5'(13 + c); bus.fpu_data = $urandom;
      bus.alloc_valid = 1'b1; bus.alloc_addr = 5'(16 + c);
      tick();
    end
    idle();
    tick();
    checks++; if (bus.wen0 !== 1'b1 || bus.waddr0 !== 5'd13 || bus.fifo_count !== 3'd2) begin failures++; $display("FAIL arst_pre: got wen=%0h addr=%0d cnt=%0d want wen=1 addr=13 cnt=2", bus.wen0, bus.waddr0, bus.fifo_count); end
    #2;
    rst_l = 1'b0;
    #1;
    checks++; if (bus.wen0 !== 1'b0 || bus.waddr0 !== 5'd0 || bus.wd0 !== 32'd0) begin failures++; $display("FAIL arst_port: got wen=%0h addr=%0d data=%0h want 0/0/0", bus.wen0, bus.waddr0, bus.wd0); end
    checks++; if (bus.fifo_count !== 3'd0 || bus.busy !== 32'd0 || bus.wr_err !== 1'b0 || bus.fpu_ready !== 1'b0) begin failures++; $display("FAIL arst_state: got cnt=%0d busy=%0h err=%0h rdy=%0h want 0/0/0/0", bus.fifo_count, bus.busy, bus.wr_err, bus.fpu_ready); end
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.wen0 !== 1'b0 || bus.fifo_count !== 3'd0) begin failures++; $display("FAIL arst_after[%0d]: got wen=%0h cnt=%0d want 0/0", k, bus.wen0, bus.fifo_count); end
    end
  endtask

  task automatic test_random();
    ent_t        q [$];
    ent_t        e;
    logic [31:0] m_busy = 32'd0;
    logic        m_err = 1'b0;
    logic        e_wen, exp_rdy, hs;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    for (int n = 0; n < 400; n++) begin
      bus.flush       = ($urandom_range(0, 15) == 0);
      bus.ld_valid    = ($urandom_range(0, 2) == 0);
      bus.ld_addr     = 5'($urandom_range(0, 7));
      bus.ld_data     = $urandom;
      bus.fpu_valid   = 1'($urandom_range(0, 1));
      bus.fpu_addr    = 5'($urandom_range(0, 7));
      bus.fpu_data    = $urandom;
      bus.alloc_valid = 1'($urandom_range(0, 1));
      bus.alloc_addr  = 5'($urandom_range(0, 7));
      #1;
      exp_rdy = !bus.flush && (q.size() < DEPTH);
      checks++; if (bus.fpu_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready[%0d]: got %0h want %0h", n, bus.fpu_ready, exp_rdy); end
      hs = bus.fpu_valid && exp_rdy;
      e_wen = 1'b0; e_a = 5'd0; e_d = 32'd0;
      if (bus.flush) begin
        q.delete(); m_busy = 32'd0; m_err = 1'b0;
      end else begin
        if (bus.ld_valid) begin
          e_wen = 1'b1; e_a = bus.ld_addr; e_d = bus.ld_data;
          if (hs) q.push_back('{a: bus.fpu_addr, d: bus.fpu_data});
        end else if (q.size() > 0) begin
          e = q.pop_front();
          e_wen = 1'b1; e_a = e.a; e_d = e.d;
          if (hs) q.push_back('{a: bus.fpu_addr, d: bus.fpu_data});
        end else if (hs) begin
          e_wen = 1'b1; e_a = bus.fpu_addr; e_d = bus.fpu_data;
        end
        if (e_wen) begin
          if (!m_busy[e_a]) m_err = 1'b1;
          m_busy[e_a] = 1'b0;
        end
        if (bus.alloc_valid) m_busy[bus.alloc_addr] = 1'b1;
      end
      tick();
      checks++; if (bus.wen0 !== e_wen) begin failures++; $display("FAIL rnd_wen0[%0d]: got %0h want %0h", n, bus.wen0, e_wen); end
      if (e_wen) begin
        checks++; if (bus.waddr0 !== e_a || bus.wd0 !== e_d) begin failures++; $display("FAIL rnd_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", n, bus.waddr0, bus.wd0, e_a, e_d); end
      end
      checks++; if (bus.busy !== m_busy) begin failures++; $display("FAIL rnd_busy[%0d]: got %0h want %0h", n, bus.busy, m_busy); end
      checks++; if (bus.fifo_count !== CW'(q.size())) begin failures++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, bus.fifo_count, q.size()); end
      checks++; if (bus.wr_err !== m_err) begin failures++; $display("FAIL rnd_err[%0d]: got %0h want %0h", n, bus.wr_err, m_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load();
    test_bypass();
    test_backpressure();
    test_alloc_collision();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
